// File: rtl/frame_uart_reader.sv
`default_nettype none
// ============================================================================
// Module      : frame_uart_reader
// Description : Frame buffer readback engine. On start it walks every pixel
//               address 0..N-1 through the buffer's 1-cycle registered read
//               port. Each 12-bit pixel goes to the UART transmitter as two
//               bytes over a valid/ready handshake: {4'h0, pix[11:8]} first,
//               then pix[7:0].
// Ports       : clk      - system clock, rising edge
//               rst_n    - synchronous active-low reset
//               start    - one-cycle request to dump the frame
//               r_en     - frame buffer read enable (one pulse per pixel)
//               r_add    - frame buffer read address
//               r_data   - frame buffer read data, valid the cycle after r_en
//               tx_data  - byte to the UART transmitter
//               tx_valid - tx_data is valid
//               tx_ready - transmitter accepts the byte this cycle
//               busy     - dump in progress
//               done     - one-cycle pulse after the last byte is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module frame_uart_reader #(
  parameter int IMAGE_WIDTH  = 4,
  parameter int IMAGE_HEIGHT = 4,
  localparam int N  = IMAGE_WIDTH * IMAGE_HEIGHT,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          r_en,
  output logic [AW-1:0] r_add,
  input  logic [11:0]   r_data,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_LATCH   = 3'd2;
  localparam logic [2:0] S_SEND_HI = 3'd3;
  localparam logic [2:0] S_SEND_LO = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [AW-1:0] addr;
  logic [11:0]   pix;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Address counter and pixel holding register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
      pix  <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        addr <= '0;
      end else if (state == S_SEND_LO && tx_ready && addr != LAST_ADDR) begin
        // The counter only advances when another pixel follows, so it
        // never leaves 0..N-1 even when N is not a power of two.
        addr <= addr + 1'b1;
      end
      if (state == S_LATCH) begin
        pix <= r_data;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_READ;
      S_READ:    next_state = S_LATCH;
      S_LATCH:   next_state = S_SEND_HI;
      S_SEND_HI: if (tx_ready) next_state = S_SEND_LO;
      S_SEND_LO: begin
        if (tx_ready) begin
          next_state = (addr == LAST_ADDR) ? S_DONE : S_READ;
        end
      end
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded purely from registered state, so they stay stable
  // for the whole cycle and hold while the transmitter stalls.
  always_comb begin
    r_en     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    r_add    = addr;
    case (state)
      S_READ:    r_en = 1'b1;
      S_SEND_HI: begin
        tx_valid = 1'b1;
        tx_data  = {4'b0000, pix[11:8]};
      end
      S_SEND_LO: begin
        tx_valid = 1'b1;
        tx_data  = pix[7:0];
      end
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
  end

endmodule
`default_nettype wire
